// File: rtl/arm_fetch_unit.sv
// -----------------------------------------------------------------------------
// arm_fetch_unit
//
// Instruction fetch stage feeding the arm core's decode stage.
//
// The unit owns the fetch PC and keeps at most one word request to instruction
// memory in flight. Returned words go into a 2-entry prefetch queue, and the
// queue head is presented to decode with a valid/ready handshake. A branch
// from execute redirects the fetch PC. It also discards everything queued and
// any response still in flight.
//
// Parameters
//   RESET_PC  fetch PC loaded on reset
//   DEPTH     prefetch queue entries; only 2 is supported
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   imem_req       one-cycle request pulse (memory always accepts)
//   imem_addr      request word address (fetch PC, low 2 bits always 0)
//   imem_rvalid    response valid, at least one cycle after imem_req
//   imem_rdata     response instruction word
//   branch_valid   redirect request from execute (highest priority)
//   branch_target  redirect address; low 2 bits ignored
//   id_ready       decode accepts the head entry this cycle
//   if_valid       head entry valid
//   if_instr       head instruction
//   if_pc          address of the head instruction
// -----------------------------------------------------------------------------
module arm_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  // IDLE: nothing in flight. WAIT: response in flight and wanted.
  // DROP: response in flight but made stale by a branch.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam logic [2:0] DEPTH_W = 3'(DEPTH);

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q;
  logic [31:0] req_addr_q;     // address of the request currently in flight
  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];
  logic        head_q;
  logic [1:0]  count_q;

  logic        push;
  logic        pop;
  logic        issue;
  logic        tail;
  logic [2:0]  occ_next;
  logic        unused_target_bits;

  assign unused_target_bits = ^branch_target[1:0];

  // A branch overrides everything: the in-flight response is not kept, and the
  // head is not consumed because the queue is being flushed anyway.
  assign push = (state_q == WAIT) && imem_rvalid && !branch_valid;
  assign pop  = if_valid && id_ready && !branch_valid;

  // Occupancy after this cycle's push/pop. A new request is only issued if that
  // occupancy still leaves a free slot, which reserves room for its response.
  assign occ_next = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};

  // rvalid -> imem_req is combinational on purpose. A returning response can
  // immediately launch the next request, giving one fetch per cycle.
  assign issue = !reset && !branch_valid
              && ((state_q == IDLE) || ((state_q == WAIT) && imem_rvalid))
              && (occ_next < DEPTH_W);

  // With two entries, tail = head + count (mod 2). When the queue is full, the
  // tail is the slot being popped in the same cycle.
  assign tail = head_q ^ count_q[0];

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign if_valid  = (count_q != 2'd0);
  assign if_instr  = q_instr[head_q];
  assign if_pc     = q_pc[head_q];

  always_comb begin
    // NOTE: state_d gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    state_d = state_q;
    if (branch_valid) begin
      unique case (state_q)
        WAIT, DROP: state_d = imem_rvalid ? IDLE : DROP;
        default:    state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: state_d = issue ? WAIT : IDLE;
        WAIT: if (imem_rvalid) state_d = issue ? WAIT : IDLE;
        DROP: if (imem_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments make every register update from the
    // values present before the edge, whatever order the statements are in.
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      if (branch_valid) begin
        fetch_pc_q <= {branch_target[31:2], 2'b00};
        count_q    <= 2'd0;
      end else begin
        if (issue) begin
          fetch_pc_q <= fetch_pc_q + 32'd4;
          req_addr_q <= fetch_pc_q;
        end
        if (pop) head_q <= ~head_q;
        count_q <= occ_next[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the queue storage is reset, unlike a plain data RAM, because
    // if_instr/if_pc are read straight from it and must read 0 out of reset.
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (push) begin
      q_instr[tail] <= imem_rdata;
      q_pc[tail]    <= req_addr_q;
    end
  end

endmodule

// File: tb/tb_arm_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_arm_fetch_unit
//
// Self-checking bench for arm_fetch_unit. It has three parts: directed table
// vectors, hand-written branch/reset sequences, and a randomized run. A
// queue-based reference model predicts every cycle's outputs. A small memory
// model answers requests after a fixed or random latency.
// -----------------------------------------------------------------------------
module tb_arm_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  always #5 clk = ~clk;

  arm_fetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .id_ready     (id_ready),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_fetch_pc;
  bit          m_out;        // a request is in flight
  bit          m_keep;       // its response is still wanted
  logic [31:0] m_out_addr;

  // ---------------- memory model ----------------
  bit          mem_busy;
  int          mem_due;
  logic [31:0] mem_addr;
  int          mem_lat;      // 0 selects a random latency of 1..4
  bit          late_inject;  // drive a stray rvalid in the next cycle
  int          cyc;

  // values sampled in the last step
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc;

  // One clock cycle: drive inputs at posedge+1, sample at negedge, run the
  // model and compare, then return at the next posedge+1.
  task automatic step(input logic br, input logic [31:0] tgt, input logic rdy);
    logic        rv;
    logic [31:0] rd;
    bit          mem_resp, resp, push, pop, e_req, e_valid;
    logic [31:0] e_addr, e_pc, e_instr;
    entry_t      ent;

    mem_resp = mem_busy && (cyc == mem_due);
    rv = mem_resp;
    rd = mem_resp ? data_of(mem_addr) : $urandom;
    if (late_inject) begin
      rv = 1'b1;
      rd = 32'hDEAD_BEEF;
      late_inject = 1'b0;
    end
    branch_valid  = br;
    branch_target = tgt;
    id_ready      = rdy;
    imem_rvalid   = rv;
    imem_rdata    = rd;

    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = if_valid;
    s_instr = if_instr;
    s_pc    = if_pc;

    e_valid = (m_q.size() != 0);
    e_pc    = e_valid ? m_q[0].pc : 32'h0;
    e_instr = e_valid ? m_q[0].instr : 32'h0;
    e_addr  = m_fetch_pc;
    if (br) begin
      e_req = 1'b0;
      m_q.delete();
      m_fetch_pc = {tgt[31:2], 2'b00};
      if (m_out) begin
        if (rv) m_out = 1'b0;
        else    m_keep = 1'b0;
      end
    end else begin
      resp  = m_out && rv;
      push  = resp && m_keep;
      pop   = e_valid && rdy;
      e_req = (!m_out || push) && ((m_q.size() + int'(push) - int'(pop)) < 2);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        ent.pc    = m_out_addr;
        ent.instr = rd;
        m_q.push_back(ent);
      end
      if (resp) m_out = 1'b0;
      if (e_req) begin
        m_out      = 1'b1;
        m_keep     = 1'b1;
        m_out_addr = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end

    check("model_req", 32'(s_req), 32'(e_req));
    if (e_req) check("model_addr", s_addr, e_addr);
    check("model_valid", 32'(s_valid), 32'(e_valid));
    if (e_valid) begin
      check("model_pc", s_pc, e_pc);
      check("model_instr", s_instr, e_instr);
    end

    if (mem_resp) mem_busy = 1'b0;
    if (s_req) begin
      check("one_outstanding", 32'(mem_busy), 32'd0);
      mem_busy = 1'b1;
      mem_due  = cyc + ((mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat);
      mem_addr = s_addr;
    end
    cyc++;

    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle and check that the outputs fall immediately, then
  // release away from the clock edge.
  task automatic do_reset(input int hold);
    reset         = 1'b1;
    branch_valid  = 1'b0;
    branch_target = 32'h0;
    id_ready      = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    #1;
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr, RESET_PC);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc",    if_pc, 32'h0);
    m_q.delete();
    m_fetch_pc = RESET_PC;
    m_out      = 1'b0;
    m_keep     = 1'b0;
    mem_busy   = 1'b0;
    cyc        = 0;
    repeat (hold) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Step with id_ready=1 until imem_req (want_req) or if_valid is seen.
  task automatic run_until(input string name, input bit want_req, input int max_cycles,
                           output int n);
    bit hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < max_cycles) begin
      step(1'b0, 32'h0, 1'b1);
      n++;
      hit = want_req ? s_req : s_valid;
    end
    check({name, "_seen"}, 32'(hit), 32'd1);
  endtask

  typedef struct {
    bit          rst;     // reset before this vector
    int          lat;
    bit          br;
    logic [31:0] tgt;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int req_cyc[$];

    // latency 1, decode always ready: one instruction per cycle
    tbl.push_back('{Y, 1, N, 32'h0, Y, Y, 32'h00, N, 32'h0});
    tbl.push_back('{N, 1, N, 32'h0, Y, Y, 32'h04, N, 32'h0});
    tbl.push_back('{N, 1, N, 32'h0, Y, Y, 32'h08, Y, 32'h0});
    tbl.push_back('{N, 1, N, 32'h0, Y, Y, 32'h0C, Y, 32'h4});
    tbl.push_back('{N, 1, N, 32'h0, Y, Y, 32'h10, Y, 32'h8});
    tbl.push_back('{N, 1, N, 32'h0, Y, Y, 32'h14, Y, 32'hC});
    // decode stalled: two requests fill the queue, then drain and resume
    tbl.push_back('{Y, 1, N, 32'h0, N, Y, 32'h00, N, 32'h0});
    tbl.push_back('{N, 1, N, 32'h0, N, Y, 32'h04, N, 32'h0});
    tbl.push_back('{N, 1, N, 32'h0, N, N, 32'h00, Y, 32'h0});
    tbl.push_back('{N, 1, N, 32'h0, N, N, 32'h00, Y, 32'h0});
    tbl.push_back('{N, 1, N, 32'h0, N, N, 32'h00, Y, 32'h0});
    tbl.push_back('{N, 1, N, 32'h0, Y, Y, 32'h08, Y, 32'h0});
    tbl.push_back('{N, 1, N, 32'h0, Y, Y, 32'h0C, Y, 32'h4});
    tbl.push_back('{N, 1, N, 32'h0, Y, Y, 32'h10, Y, 32'h8});

    reset         = 1'b1;
    branch_valid  = 1'b0;
    branch_target = 32'h0;
    id_ready      = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    late_inject   = 1'b0;
    mem_lat       = 1;
    @(posedge clk);
    #1;
    do_reset(2);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(2);
      mem_lat = tbl[i].lat;
      step(tbl[i].br, tbl[i].tgt, tbl[i].rdy);
      check("tbl_req", 32'(s_req), 32'(tbl[i].req));
      if (tbl[i].req) check("tbl_addr", s_addr, tbl[i].addr);
      check("tbl_valid", 32'(s_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        check("tbl_pc", s_pc, tbl[i].pc);
        check("tbl_instr", s_instr, data_of(tbl[i].pc));
      end
    end

    // latency 3: one request in flight, requests 3 cycles apart
    do_reset(2);
    mem_lat = 3;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (s_req) req_cyc.push_back(i);
    end
    check("lat3_nreq", 32'(req_cyc.size()), 32'd5);
    for (int k = 1; k < req_cyc.size(); k++)
      check("lat3_gap", 32'(req_cyc[k] - req_cyc[k-1]), 32'd3);

    // branch to 0x100 while the request for 0x8 is in flight
    do_reset(2);
    mem_lat = 3;
    repeat (7) step(1'b0, 32'h0, 1'b1);
    check("br100_pre_req", 32'(s_req), 32'd1);
    check("br100_pre_addr", s_addr, 32'h8);
    step(1'b1, 32'h100, 1'b1);
    check("br100_no_req", 32'(s_req), 32'd0);
    run_until("br100_req", 1'b1, 10, n);
    check("br100_req_delay", 32'(n), 32'd3);
    check("br100_addr", s_addr, 32'h100);
    run_until("br100_valid", 1'b0, 10, n);
    check("br100_pc", s_pc, 32'h100);

    // branch in the same cycle as a response: response discarded
    do_reset(2);
    mem_lat = 1;
    repeat (3) step(1'b0, 32'h0, 1'b1);
    check("brsame_pre_addr", s_addr, 32'h8);
    step(1'b1, 32'h203, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("brsame_valid", 32'(s_valid), 32'd0);
    check("brsame_req", 32'(s_req), 32'd1);
    check("brsame_addr", s_addr, 32'h200);
    run_until("brsame_valid", 1'b0, 10, n);
    check("brsame_pc", s_pc, 32'h200);

    // PC wraps from 0xFFFF_FFFC to 0
    do_reset(2);
    mem_lat = 1;
    repeat (2) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("wrap_req0", 32'(s_req), 32'd1);
    check("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b1);
    check("wrap_req1", 32'(s_req), 32'd1);
    check("wrap_addr1", s_addr, 32'h0);
    run_until("wrap_valid", 1'b0, 10, n);
    check("wrap_pc0", s_pc, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b1);
    check("wrap_pc1_valid", 32'(s_valid), 32'd1);
    check("wrap_pc1", s_pc, 32'h0);

    // reset with an entry buffered and a request in flight; stray rvalid after
    do_reset(2);
    mem_lat = 3;
    repeat (5) step(1'b0, 32'h0, 1'b0);
    check("mr_pre_valid", 32'(s_valid), 32'd1);
    do_reset(2);
    mem_lat = 1;
    late_inject = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    check("mr_req0", 32'(s_req), 32'd1);
    check("mr_addr0", s_addr, RESET_PC);
    step(1'b0, 32'h0, 1'b1);
    check("mr_stray_ignored", 32'(s_valid), 32'd0);
    check("mr_addr1", s_addr, RESET_PC + 32'd4);
    step(1'b0, 32'h0, 1'b1);
    check("mr_valid", 32'(s_valid), 32'd1);
    check("mr_pc", s_pc, RESET_PC);
    check("mr_instr", s_instr, data_of(RESET_PC));

    // randomized traffic against the reference model
    do_reset(2);
    mem_lat = 0;
    for (int i = 0; i < 4000; i++) begin
      logic        br, rdy;
      logic [31:0] tgt;
      br  = (($urandom % 12) == 0);
      tgt = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      rdy = (($urandom % 3) != 0);
      step(br, tgt, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
